// File: rtl/sfifo_pkg.sv
// Shared definitions for the synchronous FIFO: read-mode enum and the pointer wrap helper.
// Also imported by the scoreboard model so both sides use the same wrap rule.
package sfifo_pkg;

   typedef enum logic {
      SFIFO_SHOWAHEAD = 1'b0,
      SFIFO_REGOUT    = 1'b1
   } sfifo_dly_e;

   // Explicit wrap at depth-1 so non-power-of-2 depths work without masking.
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/sfifo_mem.sv
// FIFO storage: register array with synchronous write and asynchronous read.
// Contents are intentionally not reset.
module sfifo_mem
   import sfifo_pkg::*;
#(
   parameter int FIFO_D   = 12,
   parameter int FIFO_W   = 32,
   parameter int FIFO_ADR = $clog2(FIFO_D)
) (
   input  logic                clk,
   input  logic                we,
   input  logic [FIFO_ADR-1:0] waddr,
   input  logic [FIFO_W-1:0]   wd,
   input  logic [FIFO_ADR-1:0] raddr,
   output logic [FIFO_W-1:0]   rdata
);

   logic [FIFO_W-1:0] mem [FIFO_D];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wd;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sfifo_core.sv
// Single-clock FIFO with push/pop/flush, registered full/empty flags and ovf/udf pulses.
// Read data is either show-ahead (combinational head) or registered on pop.
module sfifo_core
   import sfifo_pkg::*;
#(
   parameter int FIFO_D   = 12,
   parameter int FIFO_W   = 32,
   parameter int FIFO_DLY = 0,
   parameter int FIFO_ADR = $clog2(FIFO_D)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                fifo_we,
   input  logic [FIFO_W-1:0]   fifo_wd,
   output logic                fifo_full,
   output logic                fifo_ovf,
   input  logic                fifo_re,
   output logic [FIFO_W-1:0]   fifo_rd,
   output logic                fifo_empt,
   output logic                fifo_udf,
   output logic [FIFO_ADR:0]   fifo_len,
   input  logic                fifo_fsh
);

   localparam sfifo_dly_e DLY_MODE = sfifo_dly_e'(FIFO_DLY == 1);
   localparam logic [FIFO_ADR:0] LEN_ONE = (FIFO_ADR + 1)'(1);
   localparam logic [FIFO_ADR:0] LEN_MAX = (FIFO_ADR + 1)'(FIFO_D);

   if ((FIFO_DLY != 0) && (FIFO_DLY != 1)) begin : g_bad_dly
      $error("sfifo_core: FIFO_DLY must be 0 or 1");
   end
   if (FIFO_D < 2) begin : g_bad_depth
      $error("sfifo_core: FIFO_D must be at least 2");
   end

   logic [FIFO_ADR-1:0] wptr, rptr;
   logic [FIFO_ADR:0]   len, len_next;
   logic                full, empt, ovf, udf;
   logic                push_ok, pop_ok, mem_we;
   logic [FIFO_W-1:0]   rdata;

   // Handshake: a push is taken when we & (~full | re), a pop when re & ~empt; a refused
   // request changes no state and only raises its ovf/udf pulse on the following cycle.
   assign push_ok = fifo_we & (~full | fifo_re);
   assign pop_ok  = fifo_re & ~empt;
   assign mem_we  = push_ok & ~fifo_fsh & ~rst;

   always_comb begin
      len_next = len;
      if (push_ok && !pop_ok) begin
         len_next = len + LEN_ONE;
      end else if (pop_ok && !push_ok) begin
         len_next = len - LEN_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || fifo_fsh) begin
         wptr <= '0;
         rptr <= '0;
         len  <= '0;
         empt <= 1'b1;
         full <= 1'b0;
         ovf  <= 1'b0;
         udf  <= 1'b0;
      end else begin
         if (push_ok) begin
            wptr <= FIFO_ADR'(ptr_inc(32'(wptr), FIFO_D));
         end
         if (pop_ok) begin
            rptr <= FIFO_ADR'(ptr_inc(32'(rptr), FIFO_D));
         end
         len  <= len_next;
         empt <= (len_next == '0);
         full <= (len_next == LEN_MAX);
         ovf  <= fifo_we & full & ~fifo_re;
         udf  <= fifo_re & empt;
      end
   end

   sfifo_mem #(
      .FIFO_D   (FIFO_D),
      .FIFO_W   (FIFO_W),
      .FIFO_ADR (FIFO_ADR)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wptr),
      .wd    (fifo_wd),
      .raddr (rptr),
      .rdata (rdata)
   );

   if (DLY_MODE == SFIFO_REGOUT) begin : g_regout
      logic [FIFO_W-1:0] rd_q;
      always_ff @(posedge clk) begin
         if (rst || fifo_fsh) begin
            rd_q <= '0;
         end else if (pop_ok) begin
            rd_q <= rdata;
         end
      end
      assign fifo_rd = rd_q;
   end else begin : g_showahead
      // Forced to zero while empty so unwritten memory never reaches the output.
      assign fifo_rd = empt ? '0 : rdata;
   end

   assign fifo_full = full;
   assign fifo_empt = empt;
   assign fifo_ovf  = ovf;
   assign fifo_udf  = udf;
   assign fifo_len  = len;

endmodule

// File: tb/tb_sfifo_core.sv
// Bench for sfifo_core: a show-ahead 12-deep instance checked against a queue model plus
// hand-computed values, and a registered-read 4-deep instance checked with directed vectors.
module tb_sfifo_core;

   localparam int A_D = 12;
   localparam int B_D = 4;
   localparam int W   = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         a_rst, a_we, a_re, a_fsh;
   logic [W-1:0] a_wd, a_rd;
   logic         a_full, a_empt, a_ovf, a_udf;
   logic [4:0]   a_len;

   logic         b_rst, b_we, b_re, b_fsh;
   logic [W-1:0] b_wd, b_rd;
   logic         b_full, b_empt, b_ovf, b_udf;
   logic [2:0]   b_len;

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] exp_q[$];

   sfifo_core #(.FIFO_D(A_D), .FIFO_W(W), .FIFO_DLY(0)) u_dut_a (
      .clk(clk), .rst(a_rst), .fifo_we(a_we), .fifo_wd(a_wd), .fifo_full(a_full),
      .fifo_ovf(a_ovf), .fifo_re(a_re), .fifo_rd(a_rd), .fifo_empt(a_empt),
      .fifo_udf(a_udf), .fifo_len(a_len), .fifo_fsh(a_fsh)
   );

   sfifo_core #(.FIFO_D(B_D), .FIFO_W(W), .FIFO_DLY(1)) u_dut_b (
      .clk(clk), .rst(b_rst), .fifo_we(b_we), .fifo_wd(b_wd), .fifo_full(b_full),
      .fifo_ovf(b_ovf), .fifo_re(b_re), .fifo_rd(b_rd), .fifo_empt(b_empt),
      .fifo_udf(b_udf), .fifo_len(b_len), .fifo_fsh(b_fsh)
   );

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   // One clock on instance A; the queue model predicts head, occupancy, flags and pulses.
   task automatic a_cycle(input logic we, input logic re, input logic fsh, input logic [W-1:0] wd);
      int   n;
      logic p_ok, q_ok, e_ovf, e_udf;
      n = exp_q.size();
      if (n > 0) check("a_rd_head", a_rd, exp_q[0]);
      else       check("a_rd_empty", a_rd, '0);
      p_ok  = we && ((n < A_D) || re);
      q_ok  = re && (n > 0);
      e_ovf = !fsh && we && (n == A_D) && !re;
      e_udf = !fsh && re && (n == 0);
      a_we = we; a_re = re; a_fsh = fsh; a_wd = wd;
      @(posedge clk);
      #1;
      a_we = 1'b0; a_re = 1'b0; a_fsh = 1'b0;
      if (fsh) begin
         exp_q.delete();
      end else begin
         if (q_ok) void'(exp_q.pop_front());
         if (p_ok) exp_q.push_back(wd);
      end
      n = exp_q.size();
      check("a_len",  32'(a_len),  32'(n));
      check("a_full", 32'(a_full), 32'(n == A_D));
      check("a_empt", 32'(a_empt), 32'(n == 0));
      check("a_ovf",  32'(a_ovf),  32'(e_ovf));
      check("a_udf",  32'(a_udf),  32'(e_udf));
   endtask

   task automatic b_step(input logic rst, input logic we, input logic re, input logic fsh,
                         input logic [W-1:0] wd);
      b_rst = rst; b_we = we; b_re = re; b_fsh = fsh; b_wd = wd;
      @(posedge clk);
      #1;
      b_rst = 1'b0; b_we = 1'b0; b_re = 1'b0; b_fsh = 1'b0;
   endtask

   initial begin
      a_rst = 1'b1; a_we = 1'b0; a_re = 1'b0; a_fsh = 1'b0; a_wd = '0;
      b_rst = 1'b1; b_we = 1'b0; b_re = 1'b0; b_fsh = 1'b0; b_wd = '0;

      // Reset state of instance A
      @(posedge clk);
      #1;
      a_rst = 1'b0;
      check("rst_len",  32'(a_len),  32'd0);
      check("rst_empt", 32'(a_empt), 32'd1);
      check("rst_full", 32'(a_full), 32'd0);
      check("rst_ovf",  32'(a_ovf),  32'd0);
      check("rst_udf",  32'(a_udf),  32'd0);
      check("rst_rd",   a_rd,        32'd0);

      // Fill 0x1..0xC
      for (int i = 1; i <= A_D; i++) a_cycle(1'b1, 1'b0, 1'b0, W'(i));
      check("fill_full", 32'(a_full), 32'd1);
      check("fill_len",  32'(a_len),  32'd12);

      // Overflow: 0xDEAD dropped
      a_cycle(1'b1, 1'b0, 1'b0, 32'hDEAD);
      check("ovf_pulse", 32'(a_ovf), 32'd1);
      check("ovf_len",   32'(a_len), 32'd12);
      a_cycle(1'b0, 1'b0, 1'b0, '0);
      check("ovf_clear", 32'(a_ovf), 32'd0);

      // Drain: expect 0x1..0xC in order
      for (int i = 1; i <= A_D; i++) begin
         check("drain_rd", a_rd, W'(i));
         a_cycle(1'b0, 1'b1, 1'b0, '0);
      end
      check("drain_empt", 32'(a_empt), 32'd1);
      check("drain_len",  32'(a_len),  32'd0);
      check("drain_rd0",  a_rd,        32'd0);

      // Underflow, then push+pop on empty
      a_cycle(1'b0, 1'b1, 1'b0, '0);
      check("udf_pulse", 32'(a_udf), 32'd1);
      check("udf_rd",    a_rd,       32'd0);
      a_cycle(1'b0, 1'b0, 1'b0, '0);
      a_cycle(1'b1, 1'b1, 1'b0, 32'h77);
      check("wr_empty_udf", 32'(a_udf), 32'd1);
      check("wr_empty_len", 32'(a_len), 32'd1);
      check("wr_empty_rd",  a_rd,       32'h77);
      a_cycle(1'b0, 1'b1, 1'b0, '0);

      // Wrap with simultaneous push/pop while full
      for (int i = 0; i < A_D; i++) a_cycle(1'b1, 1'b0, 1'b0, 32'h100 + W'(i));
      for (int k = 0; k < 30; k++) a_cycle(1'b1, 1'b1, 1'b0, 32'h200 + W'(k));
      check("wrap_len",  32'(a_len), 32'd12);
      check("wrap_head", a_rd,       32'h212);
      for (int i = 0; i < A_D; i++) a_cycle(1'b0, 1'b1, 1'b0, '0);

      // Flush mid-stream with we and re asserted
      for (int i = 0; i < 7; i++) a_cycle(1'b1, 1'b0, 1'b0, 32'h300 + W'(i));
      check("pre_flush_len", 32'(a_len), 32'd7);
      a_cycle(1'b1, 1'b1, 1'b1, 32'h5A);
      check("flush_len",  32'(a_len),  32'd0);
      check("flush_empt", 32'(a_empt), 32'd1);
      check("flush_ovf",  32'(a_ovf),  32'd0);
      check("flush_udf",  32'(a_udf),  32'd0);
      a_cycle(1'b1, 1'b0, 1'b0, 32'hA5);
      check("flush_a5", a_rd, 32'hA5);
      a_cycle(1'b0, 1'b1, 1'b0, '0);

      // Instance B: registered read
      b_step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      check("b_rst_rd",   b_rd,        32'd0);
      check("b_rst_len",  32'(b_len),  32'd0);
      check("b_rst_empt", 32'(b_empt), 32'd1);
      b_step(1'b0, 1'b1, 1'b0, 1'b0, 32'h11);
      b_step(1'b0, 1'b1, 1'b0, 1'b0, 32'h22);
      check("b_len2",   32'(b_len), 32'd2);
      check("b_rd_pre", b_rd,       32'd0);
      b_step(1'b0, 1'b0, 1'b1, 1'b0, '0);
      check("b_rd_11",  b_rd,       32'h11);
      check("b_len1",   32'(b_len), 32'd1);
      b_step(1'b0, 1'b0, 1'b0, 1'b0, '0);
      check("b_hold1", b_rd, 32'h11);
      b_step(1'b0, 1'b0, 1'b0, 1'b0, '0);
      check("b_hold2", b_rd, 32'h11);
      b_step(1'b0, 1'b0, 1'b1, 1'b0, '0);
      check("b_rd_22",  b_rd,        32'h22);
      check("b_empt",   32'(b_empt), 32'd1);
      b_step(1'b0, 1'b0, 1'b1, 1'b0, '0);
      check("b_udf",      32'(b_udf), 32'd1);
      check("b_udf_hold", b_rd,       32'h22);
      for (int i = 0; i < B_D; i++) b_step(1'b0, 1'b1, 1'b0, 1'b0, 32'h30 + W'(i));
      check("b_full", 32'(b_full), 32'd1);
      b_step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      check("b_mid_rst_len", 32'(b_len),  32'd0);
      check("b_mid_rst_rd",  b_rd,        32'd0);
      check("b_mid_rst_ful", 32'(b_full), 32'd0);
      b_step(1'b0, 1'b1, 1'b0, 1'b0, 32'h55);
      b_step(1'b0, 1'b0, 1'b1, 1'b0, '0);
      check("b_rd_55", b_rd, 32'h55);
      b_step(1'b0, 1'b1, 1'b0, 1'b1, 32'h66);
      check("b_fsh_rd",  b_rd,       32'd0);
      check("b_fsh_len", 32'(b_len), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
